// File: rtl/sevenseg_scan.sv
`default_nettype none
// ============================================================================
// Module   : sevenseg_scan
// Brief    : Four-digit multiplexed seven-segment driver, advanced by the
//            rising edges of a divided scan signal sampled in the clin domain.
// Revision : 1.0 - initial release
// ============================================================================
module sevenseg_scan #(
    parameter logic SEG_ACTIVE_LOW = 1'b1,
    parameter logic AN_ACTIVE_LOW  = 1'b1,
    parameter logic BLANK_LZ       = 1'b0
) (
    input  logic        clin,
    input  logic        rst,
    input  logic        tick_in,
    input  logic [15:0] value,
    input  logic [3:0]  dp,
    output logic [6:0]  seg,
    output logic        dpo,
    output logic [3:0]  an,
    output logic [1:0]  digit_idx
);

    localparam logic [3:0] c_an_off  = AN_ACTIVE_LOW  ? 4'b1111 : 4'b0000;
    localparam logic [6:0] c_seg_off = SEG_ACTIVE_LOW ? 7'h7F   : 7'h00;
    localparam logic       c_dp_off  = SEG_ACTIVE_LOW;

    logic       r_tick_q;
    logic [1:0] r_idx;

    logic       w_strobe;
    logic [1:0] w_idx_next;
    logic [3:0] w_nib;
    logic [6:0] w_dec;
    logic [6:0] w_seg_ah;
    logic [3:0] w_onehot;
    logic [3:0] w_lz;
    logic       w_blank;

    always_comb begin
        w_strobe   = tick_in & ~r_tick_q;
        w_idx_next = r_idx + {1'b0, w_strobe};
        w_nib      = value[{w_idx_next, 2'b00} +: 4];
        w_onehot   = 4'b0001 << w_idx_next;

        // A digit is a leading zero when it and every digit above it are zero.
        w_lz[3] = (value[15:12] == 4'h0);
        w_lz[2] = w_lz[3] & (value[11:8] == 4'h0);
        w_lz[1] = w_lz[2] & (value[7:4] == 4'h0);
        w_lz[0] = 1'b0;
        w_blank = BLANK_LZ & w_lz[w_idx_next];

        case (w_nib)
            4'h0:    w_dec = 7'h3F;
            4'h1:    w_dec = 7'h06;
            4'h2:    w_dec = 7'h5B;
            4'h3:    w_dec = 7'h4F;
            4'h4:    w_dec = 7'h66;
            4'h5:    w_dec = 7'h6D;
            4'h6:    w_dec = 7'h7D;
            4'h7:    w_dec = 7'h07;
            4'h8:    w_dec = 7'h7F;
            4'h9:    w_dec = 7'h6F;
            4'hA:    w_dec = 7'h77;
            4'hB:    w_dec = 7'h7C;
            4'hC:    w_dec = 7'h39;
            4'hD:    w_dec = 7'h5E;
            4'hE:    w_dec = 7'h79;
            default: w_dec = 7'h71;
        endcase

        w_seg_ah = w_blank ? 7'h00 : w_dec;
    end

    // Reset reloads the tick history so a high tick_in at release is not an edge.
    always_ff @(posedge clin) begin
        r_tick_q <= tick_in;
        if (rst) begin
            r_idx     <= 2'd0;
            digit_idx <= 2'd0;
            an        <= c_an_off;
            seg       <= c_seg_off;
            dpo       <= c_dp_off;
        end else begin
            r_idx     <= w_idx_next;
            digit_idx <= w_idx_next;
            an        <= AN_ACTIVE_LOW  ? ~w_onehot : w_onehot;
            seg       <= SEG_ACTIVE_LOW ? ~w_seg_ah : w_seg_ah;
            dpo       <= SEG_ACTIVE_LOW ? ~dp[w_idx_next] : dp[w_idx_next];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sevenseg_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_sevenseg_scan
// Brief    : Directed self-checking bench for sevenseg_scan (default and
//            leading-zero-blanking instances driven from shared inputs).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sevenseg_scan;

    logic        clin = 1'b0;
    logic        rst = 1'b1;
    logic        tick_in = 1'b1;
    logic [15:0] value = 16'h1234;
    logic [3:0]  dp = 4'b0000;

    logic [6:0]  seg_a, seg_b;
    logic        dpo_a, dpo_b;
    logic [3:0]  an_a, an_b;
    logic [1:0]  idx_a, idx_b;

    int checks = 0;
    int failures = 0;
    logic [1:0] exp_idx = 2'd0;

    always #5 clin = ~clin;

    sevenseg_scan dut (
        .clin(clin), .rst(rst), .tick_in(tick_in), .value(value), .dp(dp),
        .seg(seg_a), .dpo(dpo_a), .an(an_a), .digit_idx(idx_a)
    );

    sevenseg_scan #(.BLANK_LZ(1'b1)) dut_lz (
        .clin(clin), .rst(rst), .tick_in(tick_in), .value(value), .dp(dp),
        .seg(seg_b), .dpo(dpo_b), .an(an_b), .digit_idx(idx_b)
    );

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clin);
            #1;
        end
    endtask

    // One low cycle then a rise; returns after the edge that registers the advance.
    task automatic pulse();
        tick_in = 1'b0;
        step(1);
        tick_in = 1'b1;
        step(1);
        exp_idx = exp_idx + 2'd1;
    endtask

    task automatic test_reset();
        rst = 1'b1; tick_in = 1'b1; value = 16'h1234; dp = 4'b0000;
        step(3);
        checks++;
        if ({idx_a, an_a, seg_a, dpo_a} !== {2'd0, 4'b1111, 7'h7F, 1'b1}) begin
            failures++;
            $display("FAIL reset_state: got idx=%0d an=%b seg=%h dpo=%b want idx=0 an=1111 seg=7f dpo=1",
                     idx_a, an_a, seg_a, dpo_a);
        end
        rst = 1'b0;
        step(1);
        checks++;
        if ({idx_a, an_a, seg_a} !== {2'd0, 4'b1110, 7'h19}) begin
            failures++;
            $display("FAIL reset_release: got idx=%0d an=%b seg=%h want idx=0 an=1110 seg=19",
                     idx_a, an_a, seg_a);
        end
        step(1);
        checks++;
        if (idx_a !== 2'd0) begin
            failures++;
            $display("FAIL release_hold: got idx=%0d want 0", idx_a);
        end
        exp_idx = 2'd0;
    endtask

    task automatic test_scan();
        logic [1:0] e_idx [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
        logic [3:0] e_an  [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
        logic [6:0] e_seg [4] = '{7'h30, 7'h24, 7'h79, 7'h19};
        for (int k = 0; k < 4; k++) begin
            tick_in = 1'b0;
            step(2);
            tick_in = 1'b1;
            step(1);
            exp_idx = exp_idx + 2'd1;
            checks++;
            if ({idx_a, an_a, seg_a, dpo_a} !== {e_idx[k], e_an[k], e_seg[k], 1'b1}) begin
                failures++;
                $display("FAIL scan_%0d: got idx=%0d an=%b seg=%h dpo=%b want idx=%0d an=%b seg=%h dpo=1",
                         k, idx_a, an_a, seg_a, dpo_a, e_idx[k], e_an[k], e_seg[k]);
            end
            step(1);
            checks++;
            if (idx_a !== e_idx[k]) begin
                failures++;
                $display("FAIL scan_hold_%0d: got idx=%0d want %0d", k, idx_a, e_idx[k]);
            end
        end
    endtask

    task automatic test_long_tick();
        logic [1:0] start;
        start = exp_idx;
        tick_in = 1'b0;
        step(2);
        tick_in = 1'b1;
        step(10);
        checks++;
        if (idx_a !== start + 2'd1) begin
            failures++;
            $display("FAIL long_high: got idx=%0d want %0d", idx_a, start + 2'd1);
        end
        tick_in = 1'b0;
        step(10);
        checks++;
        if (idx_a !== start + 2'd1) begin
            failures++;
            $display("FAIL long_low: got idx=%0d want %0d", idx_a, start + 2'd1);
        end
        tick_in = 1'b1;
        step(3);
        exp_idx = start + 2'd2;
        checks++;
        if (idx_a !== exp_idx) begin
            failures++;
            $display("FAIL long_second: got idx=%0d want %0d", idx_a, exp_idx);
        end
    endtask

    task automatic test_blanking();
        // Expected segments by digit index for 16'h0070 with and without blanking.
        logic [6:0] lz_seg [4] = '{7'h40, 7'h78, 7'h7F, 7'h7F};
        logic [6:0] nb_seg [4] = '{7'h40, 7'h78, 7'h40, 7'h40};
        value = 16'h0070; dp = 4'b0100;
        step(1);
        for (int k = 0; k < 4; k++) begin
            pulse();
            checks++;
            if ({idx_b, seg_b, dpo_b, an_b} !== {exp_idx, lz_seg[exp_idx], ~(exp_idx == 2'd2), ~(4'b0001 << exp_idx)}) begin
                failures++;
                $display("FAIL blank_lz_d%0d: got idx=%0d seg=%h dpo=%b an=%b want seg=%h dpo=%b",
                         exp_idx, idx_b, seg_b, dpo_b, an_b, lz_seg[exp_idx], ~(exp_idx == 2'd2));
            end
            checks++;
            if ({seg_a, dpo_a} !== {nb_seg[exp_idx], ~(exp_idx == 2'd2)}) begin
                failures++;
                $display("FAIL noblank_d%0d: got seg=%h dpo=%b want seg=%h dpo=%b",
                         exp_idx, seg_a, dpo_a, nb_seg[exp_idx], ~(exp_idx == 2'd2));
            end
        end
        dp = 4'b0000;
    endtask

    task automatic test_value_change();
        for (int k = 0; k < 4 && exp_idx != 2'd0; k++) pulse();
        value = 16'h0000;
        step(1);
        checks++;
        if ({idx_a, seg_a} !== {2'd0, 7'h40}) begin
            failures++;
            $display("FAIL value_zero: got idx=%0d seg=%h want idx=0 seg=40", idx_a, seg_a);
        end
        value = 16'h000A;
        step(1);
        checks++;
        if ({idx_a, seg_a} !== {2'd0, 7'h08}) begin
            failures++;
            $display("FAIL value_change: got idx=%0d seg=%h want idx=0 seg=08", idx_a, seg_a);
        end
    endtask

    task automatic test_back_to_back();
        pulse();
        pulse();
        checks++;
        if (idx_a !== 2'd2) begin
            failures++;
            $display("FAIL pre_reset_idx: got idx=%0d want 2", idx_a);
        end
        tick_in = 1'b0;
        step(1);
        tick_in = 1'b1; rst = 1'b1;
        step(1);
        checks++;
        if ({idx_a, an_a, seg_a} !== {2'd0, 4'b1111, 7'h7F}) begin
            failures++;
            $display("FAIL reset_strobe: got idx=%0d an=%b seg=%h want idx=0 an=1111 seg=7f",
                     idx_a, an_a, seg_a);
        end
        rst = 1'b0;
        exp_idx = 2'd0;
        step(1);
        checks++;
        if ({idx_a, an_a, seg_a} !== {2'd0, 4'b1110, 7'h08}) begin
            failures++;
            $display("FAIL resume_d0: got idx=%0d an=%b seg=%h want idx=0 an=1110 seg=08",
                     idx_a, an_a, seg_a);
        end
        pulse();
        checks++;
        if ({idx_a, an_a, seg_a} !== {2'd1, 4'b1101, 7'h40}) begin
            failures++;
            $display("FAIL resume_d1: got idx=%0d an=%b seg=%h want idx=1 an=1101 seg=40",
                     idx_a, an_a, seg_a);
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_long_tick();
        test_blanking();
        test_value_change();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sevenseg_scan.md
Name: sevenseg_scan

Overview:
Four-digit multiplexed seven-segment display driver. It sits directly downstream of clockdiv and takes the divided clock (clout) as its scan-rate input. That input is sampled in the clin domain and is never used as a clock. Each rising edge of the divided signal advances the active digit. The block decodes a 16-bit hex value into segment and anode drives for the board display.

Parameters:
SEG_ACTIVE_LOW, 1, 1 = segment and dp outputs driven low-active; 0 = high-active.
AN_ACTIVE_LOW, 1, 1 = anode enables low-active; 0 = high-active.
BLANK_LZ, 0, 1 = leading-zero blanking on digits 3..1; 0 = all digits always shown.

Ports:
clin  input  1  system clock; all state on its rising edge.
rst  input  1  synchronous, active-high reset.
tick_in  input  1  divided clock from clockdiv clout; treated as a level, synchronous to clin.
value  input  16  digit k = value[4k+3:4k]; digit 0 is rightmost.
dp  input  4  decimal point request per digit, dp[k] for digit k, active-high.
seg  output  7  segments {g,f,e,d,c,b,a}, seg[0]=a, polarity per SEG_ACTIVE_LOW.
dpo  output  1  decimal point of active digit, polarity per SEG_ACTIVE_LOW.
an  output  4  one-hot digit enable, an[k] for digit k, polarity per AN_ACTIVE_LOW.
digit_idx  output  2  index of digit currently driven on an/seg.

Behaviour:
- Edge detect:
  - tick_q <= tick_in every cycle.
  - strobe = tick_in & ~tick_q, which gives exactly one strobe cycle per 0->1 transition of tick_in.
  - tick_in held high for any number of cycles produces one strobe only.
- Scan counter: idx (2 bits). On strobe, idx <= idx + 1, wrapping 3 -> 0. No other event changes idx.
- Outputs are registered and recomputed every clin cycle from idx_next, value and dp:
  - digit_idx <= idx_next.
  - an <= onehot(idx_next).
  - seg <= decode(value nibble at idx_next).
  - dpo <= dp[idx_next].
  - Consequence: an, seg and digit_idx change on the same edge as idx.
  - Consequence: a change on value or dp appears on seg/dpo exactly 1 cycle later, with no scan advance required.
- Decode (active-high gfedcba): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71. Bitwise-inverted (7 bits) when SEG_ACTIVE_LOW=1.
- Leading-zero blanking (BLANK_LZ=1):
  - Digit k in 3..1 is blanked when it and every higher digit are 0.
  - Digit 0 is never blanked.
  - A blanked digit has all segments off, but dpo still follows dp[k] and an still enables it, so scan timing stays uniform.
- Reset (rst=1 at an edge):
  - idx <= 0, digit_idx <= 0.
  - an <= all inactive (4'b1111 with defaults).
  - seg <= all off (7'h7F with defaults), dpo <= off.
  - tick_q <= tick_in, so tick_in already high at release produces no spurious strobe.
- Reset dominates a coincident strobe; reset mid-scan discards the current position.
- First edge after reset release with no strobe: an/seg show digit 0 (idx stays 0).
- The block has no handshake with clockdiv. Missed or extra edges only shift scan phase and never corrupt state.

Test Plan:
1. rst=1 for 3 cycles with tick_in=1, value=16'h1234 -> an=4'b1111, seg=7'h7F, dpo=1, digit_idx=0. Release rst with tick_in still 1 -> no advance. Next cycle an=4'b1110, seg=7'h19 (digit 4), digit_idx=0.
2. value=16'h1234, dp=0, defaults, tick_in from clockdiv div=4. On successive rising edges:
   - digit_idx 1,2,3,0
   - an 1101,1011,0111,1110
   - seg 30,24,79,19
   - dpo=1 throughout
3. tick_in held high 10 cycles, then low 10, then high -> digit_idx advances exactly once per 0->1 transition (two advances total).
4. BLANK_LZ=1, value=16'h0070, dp=4'b0100:
   - digit3 seg=7F
   - digit2 seg=7F with dpo=0 (dp shown)
   - digit1 seg=78
   - digit0 seg=40
5. At idx=0 with value=16'h0000, change value to 16'h000A with no tick -> seg goes 40 -> 08 exactly one cycle later; digit_idx stays 0.
6. With idx=2, assert rst in the same cycle as a strobe -> next cycle digit_idx=0, an=4'b1111, seg=7'h7F. After release, scanning resumes from digit 0.
